// File: rtl/dmem_if.sv
// MEM-stage data-memory bus between the core (master) and the responder (slave).
interface dmem_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemReadyM;
  logic        MisalignM;
  logic        StallMemM;

  modport master (
    output MemReqM, MemWriteM, ALUResultM, WriteDataM,
    input  ReadDataM, MemReadyM, MisalignM, StallMemM
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUResultM, WriteDataM,
    output ReadDataM, MemReadyM, MisalignM, StallMemM
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states; stalls the pipeline
// while a request is outstanding and pulses ready for one cycle on completion.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  dmem_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           mis_q, mis_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    mem_q [DEPTH_WORDS];
  logic           commit;
  logic [31:0]    rd_word;
  logic           unused_addr;

  // Upper address bits are deliberately ignored so accesses wrap modulo the depth.
  assign unused_addr = ^bus.ALUResultM[31:AW+2];

  assign commit  = (state_q == RESP) && we_q && !mis_q;
  assign rd_word = (commit && (idx_q == idx_d)) ? wdata_q : mem_q[idx_d];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.MemReqM) begin
          idx_d   = bus.ALUResultM[AW+1:2];
          mis_d   = |bus.ALUResultM[1:0];
          we_d    = bus.MemWriteM;
          wdata_d = bus.WriteDataM;
          cnt_d   = LAT4;
          state_d = (LAT4 == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = (cnt_q > 4'd1) ? cnt_q - 4'd1 : cnt_q;
        if (!bus.MemReqM)       state_d = IDLE;  // pipeline flush: abandon, no write
        else if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RESP && state_q != RESP) rdata_d = mis_d ? 32'd0 : rd_word;
    else if (state_q == RESP)               rdata_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array has no reset; reset only blocks a store that would commit at that edge.
  always_ff @(posedge clk) begin
    if (reset_n && commit) mem_q[idx_q] <= wdata_q;
  end

  assign bus.MemReadyM = (state_q == RESP);
  assign bus.MisalignM = (state_q == RESP) && mis_q;
  assign bus.ReadDataM = rdata_q;
  assign bus.StallMemM = bus.MemReqM && (state_q != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 and a LATENCY=0 responder driven from a vector table
// plus hand-written flush and reset sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_if m2 ();
  dmem_if m0 ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(m2));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(m0));

  typedef struct {
    bit          sel;      // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      m0.MemReqM = req; m0.MemWriteM = we; m0.ALUResultM = a; m0.WriteDataM = d;
    end else begin
      m2.MemReqM = req; m2.MemWriteM = we; m2.ALUResultM = a; m2.WriteDataM = d;
    end
  endtask

  // {ready, misalign, stall, rdata}
  function automatic logic [34:0] sample(input bit sel);
    if (sel) return {m0.MemReadyM, m0.MisalignM, m0.StallMemM, m0.ReadDataM};
    return {m2.MemReadyM, m2.MisalignM, m2.StallMemM, m2.ReadDataM};
  endfunction

  // Current cycle is cycle 0 of an accepted request; follow it to the ready pulse.
  task automatic wait_ready(input vec_t v);
    int          lat;
    logic [34:0] s;
    bit          got;
    lat = v.sel ? 0 : 2;
    got = 1'b0;
    for (int c = 0; c <= lat + 10 && !got; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      s = sample(v.sel);
      if (s[34]) begin
        got = 1'b1;
        check("latency", 32'(c), 32'(lat + 1));
        check("stall_at_ready", 32'(s[32]), 32'd0);
        check("misalign", 32'(s[33]), 32'(v.exp_mis));
        if (v.chk_rd) check("rdata", s[31:0], v.exp_rd);
        drive(v.sel, 1'b0, 1'b0, 32'd0, 32'd0);
      end else begin
        check("stall_wait", 32'(s[32]), 32'd1);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ready pulse for addr 0x%08h", v.addr);
      drive(v.sel, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic do_req(input vec_t v);
    logic [34:0] s;
    @(negedge clk);
    s = sample(v.sel);
    check("idle_ready", 32'(s[34]), 32'd0);
    check("idle_rdata", s[31:0], 32'd0);
    drive(v.sel, 1'b1, v.we, v.addr, v.wdata);
    #1;
    wait_ready(v);
  endtask

  vec_t        vecs[$];
  vec_t        v;
  logic [34:0] s;

  initial begin
    // store: ALUResultM, WriteDataM ; load: expected data ; misaligned => data 0
    vecs.push_back('{0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0,         1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 1, 32'h0,         1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0,         1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 0, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         1, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_03FC, 32'h0102_0304, 0, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0102_0304, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0043, 32'h0,         1, 32'h0,         1'b1});
    vecs.push_back('{0, 1'b1, 32'h0000_0080, 32'h2222_2222, 0, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0080, 32'h0,         1, 32'h2222_2222, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0000, 32'h1234_5678, 0, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0000, 32'h0,         1, 32'h1234_5678, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0000, 32'h0,         1, 32'h1234_5678, 1'b0});

    // Reset with a request pending: outputs idle, stall follows the request.
    drive(0, 1'b1, 1'b1, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    s = sample(0);
    check("rst_ready", 32'(s[34]), 32'd0);
    check("rst_mis", 32'(s[33]), 32'd0);
    check("rst_rdata", s[31:0], 32'd0);
    check("rst_stall_req", 32'(s[32]), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_stall_noreq", 32'(m2.StallMemM), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // Flush in WAIT: store to 0x80 abandoned in cycle 1, no ready, no write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h80, 32'h1111_1111);
    #1;
    check("flush_stall_c0", 32'(m2.StallMemM), 32'd1);
    @(negedge clk);
    #1;
    check("flush_ready_c1", 32'(m2.MemReadyM), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("flush_stall_drop", 32'(m2.StallMemM), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("flush_no_ready", 32'(m2.MemReadyM), 32'd0);
    end
    v = '{0, 1'b0, 32'h80, 32'h0, 1, 32'h2222_2222, 1'b0};
    do_req(v);

    // Reset in cycle 1 of a store; the core replaces it with a load that is re-accepted.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h80, 32'h3333_3333);
    #1;
    @(negedge clk);
    #1;
    check("rstmid_stall_c1", 32'(m2.StallMemM), 32'd1);
    reset_n = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    #1;
    s = sample(0);
    check("rstmid_ready", 32'(s[34]), 32'd0);
    check("rstmid_mis", 32'(s[33]), 32'd0);
    check("rstmid_rdata", s[31:0], 32'd0);
    check("rstmid_stall", 32'(s[32]), 32'd1);
    reset_n = 1'b1;
    wait_ready(v);

    // Array outside the aborted store is unchanged across reset.
    v = '{0, 1'b0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0};
    do_req(v);
    v = '{1, 1'b0, 32'h0, 32'h0, 1, 32'h1234_5678, 1'b0};
    do_req(v);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
